// File: rtl/fir_addr_gen_mc_pkg.sv
// fir_addr_pkg: shared types, default sizes and limit clamping for the FIR address generator
package fir_addr_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int NUM_CH_DEF = 2;
  localparam int TAP_W_DEF  = 8;
  typedef enum logic {IDLE, CZYTAJ} rd_state_t;
  function automatic logic [31:0] clamp_limit(input logic [31:0] v, input logic [31:0] depth);
    return (v > depth) ? depth : v;
  endfunction
endpackage

// File: rtl/fir_addr_gen_mc_if.sv
// fir_addr_gen_mc_if: control-FSM/address-generator bus
//   master: control side drives limit, taps, mode, channel and strobes, receives addresses/flags
//   slave : address generator side
interface fir_addr_gen_mc_if #(
  parameter int ADDR_W = 13,
  parameter int NUM_CH = 2,
  parameter int TAP_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  logic [ADDR_W:0]          ile_probek;
  logic [TAP_W-1:0]         ile_tapow;
  logic                     tryb_kolowy;
  logic [CH_W-1:0]          kanal;
  logic                     FSM_zapisz_probki;
  logic                     FSM_reset_licznik;
  logic                     FSM_nowa_probka;
  logic                     FSM_start_odczyt;
  logic                     FSM_nastepny_tap;
  logic [CH_W+ADDR_W-1:0]   A_probki_FIR;
  logic [CH_W+ADDR_W-1:0]   A_odczyt_FIR;
  logic                     licznik_full;
  logic                     licznik_wrap;
  logic                     odczyt_aktywny;
  logic                     odczyt_koniec;
  modport master (
    output ile_probek, ile_tapow, tryb_kolowy, kanal, FSM_zapisz_probki, FSM_reset_licznik,
           FSM_nowa_probka, FSM_start_odczyt, FSM_nastepny_tap,
    input  A_probki_FIR, A_odczyt_FIR, licznik_full, licznik_wrap, odczyt_aktywny, odczyt_koniec
  );
  modport slave (
    input  ile_probek, ile_tapow, tryb_kolowy, kanal, FSM_zapisz_probki, FSM_reset_licznik,
           FSM_nowa_probka, FSM_start_odczyt, FSM_nastepny_tap,
    output A_probki_FIR, A_odczyt_FIR, licznik_full, licznik_wrap, odczyt_aktywny, odczyt_koniec
  );
endinterface

// File: rtl/fir_addr_gen_mc_tap_reader.sv
// fir_tap_reader: down-counting tap read pointer FSM feeding the FIR MAC
//   clk_b/rst_n : clock, async active-low reset
//   clr_i       : abort sweep without an end pulse
//   start_i     : start sweep on ch_i from wr_ptr_i with taps_i taps
//   next_i      : advance to the next (older) tap
//   last_i      : effective limit-1, circ_i : circular mode
//   addr_o      : {rd_ch, rd_ptr}, active_o : sweep running, done_o : end pulse
module fir_tap_reader
  import fir_addr_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int TAP_W  = 8,
  parameter int CH_W   = 1
) (
  input  logic                   clk_b,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   start_i,
  input  logic                   next_i,
  input  logic [TAP_W-1:0]       taps_i,
  input  logic [CH_W-1:0]        ch_i,
  input  logic [ADDR_W-1:0]      wr_ptr_i,
  input  logic [ADDR_W-1:0]      last_i,
  input  logic                   circ_i,
  output logic [CH_W+ADDR_W-1:0] addr_o,
  output logic                   active_o,
  output logic                   done_o
);
  rd_state_t         state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TAP_W-1:0]  left_q, left_d;
  logic              done_q, done_d;
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    done_d  = 1'b0;
    if (clr_i)
      state_d = IDLE;
    else if (state_q == IDLE) begin
      if (start_i && taps_i == '0)
        done_d = 1'b1;
      else if (start_i) begin
        state_d = CZYTAJ;
        ch_d    = ch_i;
        ptr_d   = wr_ptr_i;
        left_d  = taps_i - TAP_W'(1);
      end
    end else if (next_i && left_q == '0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (next_i) begin
      // below address 0: circular wraps to the top of the buffer, linear sticks at 0
      ptr_d  = (ptr_q != '0) ? ptr_q - ADDR_W'(1) : (circ_i ? last_i : '0);
      left_d = left_q - TAP_W'(1);
    end
  end
  always_ff @(posedge clk_b or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      ptr_q   <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  assign addr_o   = {ch_q, ptr_q};
  assign active_o = (state_q == CZYTAJ);
  assign done_o   = done_q;
endmodule

// File: rtl/fir_addr_gen_mc.sv
// fir_addr_gen_mc: multi-channel FIR sample write-address counters with tap read pointer
//   clk_b : system clock, rst_n : async active-low reset
//   bus   : slave side of fir_addr_gen_mc_if (limit/mode/channel/strobes in, addresses/flags out)
module fir_addr_gen_mc
  import fir_addr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int TAP_W  = TAP_W_DEF
) (
  input logic               clk_b,
  input logic               rst_n,
  fir_addr_gen_mc_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = 1;
  logic [ADDR_W:0]   limit_q, limit_d, eff_lim, lim_m1;
  logic              tryb_q, tryb_d, wrap_q, wrap_d, zero_lin, cur_full, at_last;
  logic [ADDR_W-1:0] wr_q [NUM_CH];
  logic [ADDR_W-1:0] wr_d [NUM_CH];
  logic [NUM_CH-1:0] full_q, full_d;
  logic [31:0]       clamped;
  // limit 0 means "full" in linear mode but a whole buffer in circular mode
  assign zero_lin = (limit_q == '0) && !tryb_q;
  assign eff_lim  = (limit_q == '0) ? DEPTH : limit_q;
  assign lim_m1   = eff_lim - ONE;
  assign cur_full = full_q[bus.kanal] | zero_lin;
  assign at_last  = ({1'b0, wr_q[bus.kanal]} == lim_m1);
  assign clamped  = clamp_limit(32'(bus.ile_probek), 32'(DEPTH));
  always_comb begin
    wr_d    = wr_q;
    full_d  = full_q;
    wrap_d  = 1'b0;
    limit_d = bus.FSM_zapisz_probki ? (ADDR_W+1)'(clamped) : limit_q;
    tryb_d  = bus.FSM_zapisz_probki ? bus.tryb_kolowy : tryb_q;
    if (bus.FSM_reset_licznik) begin
      for (int i = 0; i < NUM_CH; i++) wr_d[i] = '0;
      full_d = '0;
    end else if (bus.FSM_nowa_probka && (tryb_q || !cur_full)) begin
      if (at_last) begin
        full_d[bus.kanal] = 1'b1;
        wr_d[bus.kanal]   = tryb_q ? '0 : wr_q[bus.kanal];
        wrap_d            = tryb_q;
      end else
        wr_d[bus.kanal] = wr_q[bus.kanal] + ADDR_W'(1);
    end
  end
  always_ff @(posedge clk_b or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) wr_q[i] <= '0;
      full_q  <= '0;
      wrap_q  <= 1'b0;
      limit_q <= DEPTH;
      tryb_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      full_q  <= full_d;
      wrap_q  <= wrap_d;
      limit_q <= limit_d;
      tryb_q  <= tryb_d;
    end
  fir_tap_reader #(.ADDR_W(ADDR_W), .TAP_W(TAP_W), .CH_W(CH_W)) u_rd (
    .clk_b   (clk_b),
    .rst_n   (rst_n),
    .clr_i   (bus.FSM_reset_licznik),
    .start_i (bus.FSM_start_odczyt),
    .next_i  (bus.FSM_nastepny_tap),
    .taps_i  (bus.ile_tapow),
    .ch_i    (bus.kanal),
    .wr_ptr_i(wr_q[bus.kanal]),
    .last_i  (lim_m1[ADDR_W-1:0]),
    .circ_i  (tryb_q),
    .addr_o  (bus.A_odczyt_FIR),
    .active_o(bus.odczyt_aktywny),
    .done_o  (bus.odczyt_koniec)
  );
  assign bus.A_probki_FIR = {bus.kanal, wr_q[bus.kanal]};
  assign bus.licznik_full = cur_full;
  assign bus.licznik_wrap = wrap_q;
endmodule
